ifu_prefetch: RTL and testbench
===============================

IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter XLEN, default 64, address and PC width.
REQ-002 Parameter BUS_W, default 64, memory response data width; SHALL be 32, 64 or 128; K = BUS_W/32 slots per word.
REQ-003 Parameter DEPTH, default 4, instruction queue entries; SHALL be a power of two and at least K.
REQ-004 Parameter RESET_PC, default 64'h8000_0000, fetch PC after reset.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 redirect_valid  in  1  flush the queue and restart fetch at redirect_pc (branch, trap, mret).
REQ-008 redirect_pc  in  XLEN  new fetch PC; bits [1:0] are ignored and treated as 0.
REQ-009 mem_req_valid  out  1  read request valid.
REQ-010 mem_req_ready  in  1  memory accepts the request.
REQ-011 mem_req_addr  out  XLEN  request address, aligned to BUS_W/8.
REQ-012 mem_resp_valid  in  1  response valid, at most one per accepted request, always in order.
REQ-013 mem_resp_data  in  BUS_W  response word; slot i occupies bits [32i+31:32i].
REQ-014 mem_resp_err  in  1  access fault flag for this response.
REQ-015 inst_valid  out  1  queue head valid.
REQ-016 inst_ready  in  1  consumer accepts the head.
REQ-017 inst  out  32  head instruction.
REQ-018 inst_pc  out  XLEN  PC of the head instruction.
REQ-019 inst_err  out  1  head instruction carries an access fault.

Function
REQ-020 Fetch control SHALL be an FSM with states IDLE, REQ, WAIT, DRAIN and HALT, and SHALL allow at most one outstanding request.
REQ-021 IDLE->REQ SHALL occur when free queue entries >= K and no redirect is active; otherwise the FSM SHALL stay in IDLE.
REQ-022 In REQ, mem_req_valid SHALL be 1 and mem_req_addr SHALL be fetch_pc with its low log2(BUS_W/8) bits cleared; both SHALL hold stable until mem_req_ready, then the FSM SHALL go to WAIT.
REQ-023 A WAIT response without error SHALL push slots s..K-1 in one cycle, where s = fetch_pc[log2(BUS_W/8)-1:2]. Each pushed entry's PC SHALL be word base + 4*slot, and err SHALL be 0.
REQ-024 After the push, fetch_pc SHALL advance to the next aligned word, wrapping modulo 2^XLEN, and the FSM SHALL go to IDLE.
REQ-025 A WAIT response with mem_resp_err=1 SHALL push one entry {inst=0, pc=fetch_pc, err=1}. The FSM SHALL then enter HALT, which issues no requests until a redirect.
REQ-026 inst_valid SHALL be 1 exactly when the queue is non-empty. A pop SHALL occur on inst_valid & inst_ready. Push and pop in the same cycle SHALL both take effect.
REQ-027 Latency: the first instruction after a response SHALL be visible on inst_* in the cycle after mem_resp_valid.
REQ-028 Redirect SHALL empty the queue at the next edge and load fetch_pc <= redirect_pc.
REQ-029 A head pop in the redirect cycle counts as consumed.
REQ-030 Redirect in IDLE or HALT SHALL go to IDLE.
REQ-031 Redirect in REQ SHALL keep the request stable; the FSM SHALL then go to DRAIN on acceptance, or to DRAIN immediately if accepted that cycle.
REQ-032 Redirect in WAIT without a response SHALL go to DRAIN.
REQ-033 Redirect coincident with a response SHALL discard the response and go to IDLE.
REQ-034 DRAIN SHALL discard the next response, whether error or not, then go to IDLE. A further redirect in DRAIN SHALL update fetch_pc and stay in DRAIN.
REQ-035 mem_resp_valid in IDLE, REQ or HALT SHALL be ignored.

Reset
REQ-036 On rst assertion, asynchronously: state=IDLE, fetch_pc=RESET_PC, queue empty, mem_req_valid=0, mem_req_addr=0, inst_valid=0, inst=0, inst_pc=0, inst_err=0.
REQ-037 Reset mid-request SHALL abandon the outstanding response. The first request after deassertion SHALL occur no earlier than the second rising edge.

Structure
REQ-038 Shared package ifu_pkg SHALL hold the FSM state enum, the instruction width (32) and the queue entry struct {inst, pc, err}.
REQ-039 The queue SHALL be a sub-module ifu_fifo (K-wide push, single pop, count output), with pointers wrapping modulo DEPTH.

Verification
REQ-040 Reset release, BUS_W=64, memory zero-wait -> first request at 0x8000_0000. Word 0x00000013_00100093 SHALL yield inst 0x00100093 @0x80000000, then 0x00000013 @0x80000004.
REQ-041 Redirect to 0x80000104 -> request addr 0x80000100 -> only slot 1 pushed, inst_pc=0x80000104; next request 0x80000108.
REQ-042 inst_ready=0, DEPTH=4, K=2 -> exactly two requests issued, queue full, no third request until a pop frees 2 entries.
REQ-043 Redirect to 0x80000200 while in WAIT -> stale response dropped (inst_valid stays 0), next request 0x80000200.
REQ-044 mem_resp_err=1 at 0x80000010 -> one entry {0, 0x80000010, err=1}, no further requests until redirect.
REQ-045 fetch_pc=0xFFFF_FFFF_FFFF_FFF8 -> after response next request addr 0x0.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared fetch-unit types (FSM states, instruction width, queue entry)
package ifu_pkg;
    localparam int ILEN = 32;
    localparam int PC_W = 64;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HALT} ifu_state_t;
    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [PC_W-1:0] pc;
        logic            err;
    } ifu_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: instruction queue with up-to-K-entry push, single pop and occupancy count
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int K = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [CW-1:0] push_n,
    input  ifu_entry_t    push_data [K],
    input  logic          pop,
    output logic [CW-1:0] count,
    output ifu_entry_t    head
);
    ifu_entry_t mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    always_ff @(posedge clk)
        for (int i = 0; i < K; i++)
            if (!flush && i < int'(push_n)) mem[wptr + AW'(i)] <= push_data[i];
    always_ff @(posedge clk or posedge rst)
        if (rst || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(push_n);
            rptr  <= rptr + AW'(pop);
            count <= count + push_n - CW'(pop);
        end
    assign head = mem[rptr];
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetcher, one outstanding bus read feeding an instruction queue
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int BUS_W = 64,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [BUS_W-1:0] mem_resp_data,
    input  logic            mem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err
);
    localparam int K = BUS_W / 32;
    localparam int OFF = $clog2(BUS_W / 8);
    localparam int SB = K > 1 ? $clog2(K) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    ifu_state_t state, nstate;
    logic [XLEN-1:0] fetch_pc, req_addr, base;
    logic [SB-1:0] s;
    logic [CW-1:0] count, push_n, free;
    logic kill, take, unused;
    ifu_entry_t push_data [K];
    ifu_entry_t head;

    assign unused = ^redirect_pc[1:0];
    assign base = {fetch_pc[XLEN-1:OFF], {OFF{1'b0}}};
    assign s = SB'(fetch_pc[XLEN-1:2]) & SB'(K - 1);
    assign free = CW'(DEPTH) - count;
    assign take = state == WAIT && mem_resp_valid && !redirect_valid;
    assign push_n = !take ? '0 : mem_resp_err ? CW'(1) : CW'(K) - CW'(s);

    always_comb
        for (int i = 0; i < K; i++) begin
            push_data[i].inst = mem_resp_err ? '0 : mem_resp_data[32 * int'(SB'(s + SB'(i))) +: 32];
            push_data[i].pc   = mem_resp_err ? PC_W'(fetch_pc) : PC_W'(base + XLEN'({s + SB'(i), 2'b00}));
            push_data[i].err  = mem_resp_err;
        end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = !redirect_valid && free >= CW'(K) ? REQ : IDLE;
            REQ:     if (mem_req_ready) nstate = redirect_valid || kill ? DRAIN : WAIT;
            WAIT:    if (mem_resp_valid) nstate = !redirect_valid && mem_resp_err ? HALT : IDLE;
                     else if (redirect_valid) nstate = DRAIN;
            DRAIN:   if (mem_resp_valid) nstate = IDLE;
            HALT:    if (redirect_valid) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // kill remembers a redirect seen while the request was still waiting for acceptance
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= '0;
            kill     <= 1'b0;
        end else begin
            state <= nstate;
            kill  <= state == REQ && !mem_req_ready && (kill || redirect_valid);
            if (state == IDLE && nstate == REQ) req_addr <= base;
            if (redirect_valid) fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            else if (take && !mem_resp_err) fetch_pc <= base + XLEN'(BUS_W / 8);
        end

    ifu_fifo #(.DEPTH(DEPTH), .K(K)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(redirect_valid),
        .push_n(push_n),
        .push_data(push_data),
        .pop(inst_valid && inst_ready),
        .count(count),
        .head(head)
    );

    assign mem_req_valid = state == REQ;
    assign mem_req_addr = mem_req_valid ? req_addr : '0;
    assign inst_valid = count != '0;
    assign inst = inst_valid ? head.inst : '0;
    assign inst_pc = inst_valid ? XLEN'(head.pc) : '0;
    assign inst_err = inst_valid && head.err;
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed scenarios plus randomized run against a queue-based fetch model
module tb_ifu_prefetch;
    localparam logic [63:0] RST_PC = 64'h8000_0000;
    logic clk = 0, rst = 1, redirect_valid = 0, mem_req_ready = 0, mem_resp_valid = 0;
    logic mem_resp_err = 0, inst_ready = 0;
    logic [63:0] redirect_pc = 0, mem_resp_data = 0, mem_req_addr, inst_pc;
    logic mem_req_valid, inst_valid, inst_err;
    logic [31:0] inst;
    int errors = 0, checks = 0;
    int lat_min = 0, lat_max = 0, req_cnt = 0, pend_dly = 0;
    bit rdy_rand = 0, err_rand = 0, err_en = 0, have_pend = 0;
    logic [63:0] err_addr = 0, ovr_addr = '1, ovr_data = 0, pend_addr = 0;
    typedef struct {logic [31:0] i; logic [63:0] pc; logic e;} ent_t;

    always #5 clk = ~clk;

    ifu_prefetch dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_err(inst_err)
    );

    function automatic logic [31:0] f(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [63:0] word(input logic [63:0] a);
        return a == ovr_addr ? ovr_data : {f(a + 64'd4), f(a)};
    endfunction

    // memory: accepts one request, answers after lat_min..lat_max cycles
    initial forever begin
        @(negedge clk);
        mem_resp_valid = 0;
        mem_resp_err = 0;
        mem_resp_data = 0;
        if (rst) have_pend = 0;
        else if (have_pend) begin
            if (pend_dly == 0) begin
                mem_resp_valid = 1;
                mem_resp_data = word(pend_addr);
                mem_resp_err = (err_en && pend_addr == err_addr) || (err_rand && $urandom_range(0, 15) == 0);
                have_pend = 0;
            end else pend_dly--;
        end
        mem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!rst && mem_req_valid && mem_req_ready) begin
            have_pend = 1;
            pend_addr = mem_req_addr;
            pend_dly = int'($urandom_range(lat_max, lat_min));
            req_cnt++;
        end
    end

    task automatic do_reset();
        rst = 1;
        inst_ready = 0;
        redirect_valid = 0;
        repeat (3) @(negedge clk);
        rst = 0;
    endtask

    task automatic redir(input logic [63:0] pc);
        redirect_valid = 1;
        redirect_pc = pc;
        @(negedge clk);
        redirect_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1) begin errors++; $display("FAIL reset_prefill: inst_valid=%b want 1", inst_valid); end
        rst = 1;
        #1;
        checks++;
        if ({mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, inst_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req_v=%b addr=%h iv=%b inst=%h pc=%h err=%b want all 0",
                     mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, inst_err);
        end
        @(negedge clk);
        rst = 0;
        checks++;
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_release_idle: req_v=%b want 0", mem_req_valid); end
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_first_req: req_v=%b addr=%h want 1 %h", mem_req_valid, mem_req_addr, RST_PC);
        end
    endtask

    task automatic test_basic();
        ovr_addr = RST_PC;
        ovr_data = 64'h00000013_00100093;
        do_reset();
        for (int n = 0; n < 20 && mem_req_valid !== 1'b1; n++) @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL basic_req: req_v=%b addr=%h want 1 %h", mem_req_valid, mem_req_addr, RST_PC);
        end
        for (int n = 0; n < 20 && inst_valid !== 1'b1; n++) @(negedge clk);
        checks++;
        if ({inst_valid, inst, inst_pc, inst_err} !== {1'b1, 32'h00100093, RST_PC, 1'b0}) begin
            errors++;
            $display("FAIL basic_slot0: iv=%b inst=%h pc=%h err=%b want 1 00100093 %h 0", inst_valid, inst, inst_pc, inst_err, RST_PC);
        end
        inst_ready = 1;
        @(negedge clk);
        inst_ready = 0;
        checks++;
        if ({inst_valid, inst, inst_pc, inst_err} !== {1'b1, 32'h00000013, RST_PC + 64'd4, 1'b0}) begin
            errors++;
            $display("FAIL basic_slot1: iv=%b inst=%h pc=%h err=%b want 1 00000013 %h 0", inst_valid, inst, inst_pc, inst_err, RST_PC + 64'd4);
        end
        ovr_addr = '1;
    endtask

    task automatic test_redirect_slot();
        do_reset();
        repeat (20) @(negedge clk);
        redir(64'h8000_0104);
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: iv=%b want 0", inst_valid); end
        for (int n = 0; n < 20 && mem_req_valid !== 1'b1; n++) @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0100) begin
            errors++;
            $display("FAIL redir_req: req_v=%b addr=%h want 1 80000100", mem_req_valid, mem_req_addr);
        end
        for (int n = 0; n < 20 && inst_valid !== 1'b1; n++) @(negedge clk);
        checks++;
        if ({inst_valid, inst, inst_pc, inst_err} !== {1'b1, f(64'h8000_0104), 64'h8000_0104, 1'b0}) begin
            errors++;
            $display("FAIL redir_slot1: iv=%b inst=%h pc=%h err=%b want 1 %h 80000104 0", inst_valid, inst, inst_pc, inst_err, f(64'h8000_0104));
        end
        for (int n = 0; n < 20 && mem_req_valid !== 1'b1; n++) @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0108) begin
            errors++;
            $display("FAIL redir_next_req: req_v=%b addr=%h want 1 80000108", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_full();
        int c0;
        do_reset();
        c0 = req_cnt;
        repeat (40) @(negedge clk);
        checks++;
        if (req_cnt - c0 != 2 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_two_reqs: reqs=%0d iv=%b want 2 1", req_cnt - c0, inst_valid);
        end
        inst_ready = 1;
        @(negedge clk);
        inst_ready = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (req_cnt - c0 != 2) begin errors++; $display("FAIL full_one_free: reqs=%0d want 2", req_cnt - c0); end
        inst_ready = 1;
        @(negedge clk);
        inst_ready = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (req_cnt - c0 != 3) begin errors++; $display("FAIL full_two_free: reqs=%0d want 3", req_cnt - c0); end
    endtask

    task automatic test_redirect_wait();
        bit seen = 0;
        lat_min = 4;
        lat_max = 4;
        do_reset();
        for (int n = 0; n < 20 && mem_req_valid !== 1'b1; n++) @(negedge clk);
        for (int n = 0; n < 20 && mem_req_valid !== 1'b0; n++) @(negedge clk);
        redir(64'h8000_0200);
        for (int n = 0; n < 40 && mem_req_valid !== 1'b1; n++) begin
            seen |= inst_valid;
            @(negedge clk);
        end
        checks++;
        if (seen || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0200) begin
            errors++;
            $display("FAIL wait_redirect: stale_seen=%b req_v=%b addr=%h want 0 1 80000200", seen, mem_req_valid, mem_req_addr);
        end
        for (int n = 0; n < 20 && inst_valid !== 1'b1; n++) @(negedge clk);
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, f(64'h8000_0200), 64'h8000_0200}) begin
            errors++;
            $display("FAIL wait_redirect_head: iv=%b inst=%h pc=%h want 1 %h 80000200", inst_valid, inst, inst_pc, f(64'h8000_0200));
        end
        lat_min = 0;
        lat_max = 0;
    endtask

    task automatic test_err();
        int c;
        do_reset();
        repeat (20) @(negedge clk);
        err_en = 1;
        err_addr = 64'h8000_0010;
        redir(64'h8000_0010);
        for (int n = 0; n < 20 && inst_valid !== 1'b1; n++) @(negedge clk);
        checks++;
        if ({inst_valid, inst, inst_pc, inst_err} !== {1'b1, 32'h0, 64'h8000_0010, 1'b1}) begin
            errors++;
            $display("FAIL err_entry: iv=%b inst=%h pc=%h err=%b want 1 0 80000010 1", inst_valid, inst, inst_pc, inst_err);
        end
        c = req_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (req_cnt != c || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_halt: extra_reqs=%0d req_v=%b want 0 0", req_cnt - c, mem_req_valid);
        end
        inst_ready = 1;
        @(negedge clk);
        inst_ready = 0;
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL err_pop: iv=%b want 0", inst_valid); end
        err_en = 0;
        redir(64'h8000_0020);
        for (int n = 0; n < 20 && mem_req_valid !== 1'b1; n++) @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0020) begin
            errors++;
            $display("FAIL err_resume: req_v=%b addr=%h want 1 80000020", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (20) @(negedge clk);
        redir(64'hFFFF_FFFF_FFFF_FFF8);
        for (int n = 0; n < 20 && mem_req_valid !== 1'b1; n++) @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin
            errors++;
            $display("FAIL wrap_req: req_v=%b addr=%h want 1 fffffffffffffff8", mem_req_valid, mem_req_addr);
        end
        for (int n = 0; n < 20 && mem_req_valid !== 1'b0; n++) @(negedge clk);
        for (int n = 0; n < 20 && mem_req_valid !== 1'b1; n++) @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h0) begin
            errors++;
            $display("FAIL wrap_next: req_v=%b addr=%h want 1 0", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        logic [63:0] epc, raddr, oaddr, w, ep;
        logic [31:0] ei;
        logic ev, ee;
        bit ropen = 0, rstale = 0, oopen = 0, ostale = 0, halted = 0;
        epc = RST_PC;
        raddr = 0;
        oaddr = 0;
        rdy_rand = 1;
        err_rand = 1;
        lat_min = 0;
        lat_max = 3;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            if (mem_req_valid) begin
                checks++;
                if (!ropen) begin
                    if (mem_req_addr !== {epc[63:3], 3'b0} || q.size() > 2 || halted) begin
                        errors++;
                        $display("FAIL rand_req_start: cyc=%0d addr=%h want %h qsize=%0d halted=%b", cyc, mem_req_addr, {epc[63:3], 3'b0}, q.size(), halted);
                    end
                    ropen = 1;
                    rstale = 0;
                    raddr = mem_req_addr;
                end else if (mem_req_addr !== raddr) begin
                    errors++;
                    $display("FAIL rand_req_stable: cyc=%0d addr=%h want %h", cyc, mem_req_addr, raddr);
                end
            end
            if (inst_valid && inst_ready && q.size() > 0) void'(q.pop_front());
            if (mem_resp_valid && oopen) begin
                oopen = 0;
                if (!ostale && !redirect_valid) begin
                    if (mem_resp_err) begin
                        q.push_back('{32'h0, epc, 1'b1});
                        halted = 1;
                    end else begin
                        w = word(oaddr);
                        for (int i = int'(epc[2]); i < 2; i++) q.push_back('{w[32*i +: 32], oaddr + 64'(4 * i), 1'b0});
                        epc = oaddr + 64'd8;
                    end
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                if (redirect_valid) rstale = 1;
                oopen = 1;
                oaddr = raddr;
                ostale = rstale;
                ropen = 0;
            end else if (ropen && redirect_valid) rstale = 1;
            if (redirect_valid) begin
                q.delete();
                epc = {redirect_pc[63:2], 2'b00};
                halted = 0;
                if (oopen) ostale = 1;
            end
            @(negedge clk);
            ev = q.size() != 0;
            ei = ev ? q[0].i : 32'h0;
            ep = ev ? q[0].pc : 64'h0;
            ee = ev ? q[0].e : 1'b0;
            checks++;
            if ({inst_valid, inst, inst_pc, inst_err} !== {ev, ei, ep, ee}) begin
                errors++;
                $display("FAIL rand_head: cyc=%0d got iv=%b inst=%h pc=%h err=%b want %b %h %h %b", cyc, inst_valid, inst, inst_pc, inst_err, ev, ei, ep, ee);
            end
            inst_ready = $urandom_range(0, 2) != 0;
            redirect_valid = $urandom_range(0, 19) == 0;
            redirect_pc = 64'h8000_0000 + 64'($urandom_range(0, 255) << 2) + 64'($urandom_range(0, 3));
        end
        redirect_valid = 0;
        inst_ready = 0;
        rdy_rand = 0;
        err_rand = 0;
        lat_max = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_redirect_slot();
        test_full();
        test_redirect_wait();
        test_err();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
